// File: rtl/scan_pattern_decoder.sv
// Decodes a two-wide bouncing LED scan bus: recovers head position and direction,
// and flags any frame that is not the legal successor of the previous one.
module scan_pattern_decoder #(
   parameter int N_LED = 10,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sample,
   input  logic [N_LED-1:0] led_in,
   output logic [3:0]       pos,
   output logic             dir,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] bounce_count,
   output logic [1:0]       fsm_state
);

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ACQUIRE  = 2'd1,
      LOCKED   = 2'd2
   } state_t;

   localparam logic [3:0] TOP = 4'(N_LED);

   state_t     state, state_next;
   logic [3:0] pos_next;
   logic       dir_next;
   logic       err_next;
   logic       bounce_next;
   logic       frame_legal;
   logic [3:0] frame_pos;
   logic [3:0] exp_pos;
   logic       exp_flip;

   // Physical bits of the head-p pattern: virtual v[p], v[p+1] with v[i+1] = led_in[i].
   function automatic logic [N_LED-1:0] head_mask(input int p);
      logic [N_LED+1:0] v;
      v       = '0;
      v[p]    = 1'b1;
      v[p+1]  = 1'b1;
      return v[N_LED:1];
   endfunction

   always_comb begin
      frame_legal = 1'b0;
      frame_pos   = '0;
      for (int p = 0; p <= N_LED; p++) begin
         if (led_in == head_mask(p)) begin
            frame_legal = 1'b1;
            frame_pos   = 4'(p);
         end
      end
   end

   always_comb begin
      exp_flip = 1'b0;
      exp_pos  = '0;
      if (!dir) begin
         if (pos == TOP) begin
            exp_pos  = TOP - 4'd1;
            exp_flip = 1'b1;
         end else begin
            exp_pos = pos + 4'd1;
         end
      end else begin
         if (pos == 4'd0) begin
            exp_pos  = 4'd1;
            exp_flip = 1'b1;
         end else begin
            exp_pos = pos - 4'd1;
         end
      end
   end

   // state register and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= UNLOCKED;
         pos          <= '0;
         dir          <= 1'b0;
         err          <= 1'b0;
         err_count    <= '0;
         bounce_count <= '0;
      end else begin
         state <= state_next;
         pos   <= pos_next;
         dir   <= dir_next;
         err   <= err_next;
         if (err_next && (err_count != '1))
            err_count <= err_count + CNT_W'(1);
         if (bounce_next && (bounce_count != '1))
            bounce_count <= bounce_count + CNT_W'(1);
      end
   end

   // next-state logic
   always_comb begin
      state_next  = state;
      pos_next    = pos;
      dir_next    = dir;
      err_next    = 1'b0;
      bounce_next = 1'b0;
      if (sample) begin
         case (state)
            UNLOCKED: begin
               if (frame_legal) begin
                  pos_next   = frame_pos;
                  state_next = ACQUIRE;
               end
            end
            ACQUIRE: begin
               if (!frame_legal) begin
                  state_next = UNLOCKED;
               end else if (frame_pos == pos + 4'd1) begin
                  dir_next   = 1'b0;
                  pos_next   = frame_pos;
                  state_next = LOCKED;
               end else if (frame_pos == pos - 4'd1) begin
                  dir_next   = 1'b1;
                  pos_next   = frame_pos;
                  state_next = LOCKED;
               end else begin
                  pos_next = frame_pos;
               end
            end
            LOCKED: begin
               if (frame_legal && (frame_pos == exp_pos)) begin
                  pos_next = exp_pos;
                  if (exp_flip) begin
                     dir_next    = ~dir;
                     bounce_next = 1'b1;
                  end
               end else if (!(frame_legal && (frame_pos == pos))) begin
                  // pos and dir keep their last good values for inspection
                  err_next   = 1'b1;
                  state_next = UNLOCKED;
               end
            end
            default: state_next = UNLOCKED;
         endcase
      end
   end

   // output logic
   always_comb begin
      locked    = (state == LOCKED);
      fsm_state = state;
   end

endmodule

// File: tb/tb_scan_pattern_decoder.sv
// Directed bench for scan_pattern_decoder: a vector table plus hand-written
// sequences for idle hold, counter saturation and mid-sweep reset.
module tb_scan_pattern_decoder;

   logic       clk;
   logic       reset;
   logic       sample;
   logic [9:0] led_in;
   logic [3:0] pos;
   logic       dir;
   logic       locked;
   logic       err;
   logic [7:0] err_count;
   logic [7:0] bounce_count;
   logic [1:0] fsm_state;

   int n_cmp;
   int n_bad;

   scan_pattern_decoder #(.N_LED(10), .CNT_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .sample       (sample),
      .led_in       (led_in),
      .pos          (pos),
      .dir          (dir),
      .locked       (locked),
      .err          (err),
      .err_count    (err_count),
      .bounce_count (bounce_count),
      .fsm_state    (fsm_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       smp;
      logic [9:0] led;
      logic [3:0] pos;
      logic       dir;
      logic       lk;
      logic       err;
      logic [7:0] ec;
      logic [7:0] bc;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic smp, input logic [9:0] led,
                      input logic [3:0] p, input logic d, input logic lk,
                      input logic e, input logic [7:0] ec, input logic [7:0] bc);
      vec_t v;
      v = '{rst, smp, led, p, d, lk, e, ec, bc};
      vecs.push_back(v);
   endtask

   task automatic add_s(input logic [9:0] led, input logic [3:0] p, input logic d,
                        input logic lk, input logic e, input logic [7:0] ec,
                        input logic [7:0] bc);
      add(1'b0, 1'b1, led, p, d, lk, e, ec, bc);
   endtask

   task automatic step(input logic rst, input logic smp, input logic [9:0] led);
      @(negedge clk);
      reset  = rst;
      sample = smp;
      led_in = led;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int idx,
                        input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, got, want);
      end
   endtask

   task automatic check_all(input int idx, input logic [3:0] p, input logic d,
                            input logic lk, input logic e, input logic [7:0] ec,
                            input logic [7:0] bc);
      check("pos", idx, 32'(pos), 32'(p));
      check("dir", idx, 32'(dir), 32'(d));
      check("locked", idx, 32'(locked), 32'(lk));
      check("err", idx, 32'(err), 32'(e));
      check("err_count", idx, 32'(err_count), 32'(ec));
      check("bounce_count", idx, 32'(bounce_count), 32'(bc));
   endtask

   initial begin
      n_cmp  = 0;
      n_bad  = 0;
      reset  = 1'b1;
      sample = 1'b0;
      led_in = '0;

      //      frame   pos   dir  lk   err  ec  bc
      add(1'b1, 1'b0, 10'h000, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      add_s(10'h001, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      add_s(10'h003, 4'd1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
      add_s(10'h006, 4'd2, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
      add_s(10'h00C, 4'd3, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
      add_s(10'h018, 4'd4, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
      add_s(10'h030, 4'd5, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
      add_s(10'h060, 4'd6, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
      add_s(10'h0C0, 4'd7, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
      add_s(10'h180, 4'd8, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
      add_s(10'h300, 4'd9, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
      add_s(10'h200, 4'd10, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
      add_s(10'h300, 4'd9, 1'b1, 1'b1, 1'b0, 8'd0, 8'd1);
      add_s(10'h180, 4'd8, 1'b1, 1'b1, 1'b0, 8'd0, 8'd1);
      add_s(10'h0C0, 4'd7, 1'b1, 1'b1, 1'b0, 8'd0, 8'd1);
      add_s(10'h060, 4'd6, 1'b1, 1'b1, 1'b0, 8'd0, 8'd1);
      add_s(10'h030, 4'd5, 1'b1, 1'b1, 1'b0, 8'd0, 8'd1);
      add_s(10'h018, 4'd4, 1'b1, 1'b1, 1'b0, 8'd0, 8'd1);
      add_s(10'h00C, 4'd3, 1'b1, 1'b1, 1'b0, 8'd0, 8'd1);
      add_s(10'h006, 4'd2, 1'b1, 1'b1, 1'b0, 8'd0, 8'd1);
      add_s(10'h003, 4'd1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd1);
      add_s(10'h001, 4'd0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd1);
      add_s(10'h003, 4'd1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd2);
      add_s(10'h006, 4'd2, 1'b0, 1'b1, 1'b0, 8'd0, 8'd2);
      add_s(10'h00C, 4'd3, 1'b0, 1'b1, 1'b0, 8'd0, 8'd2);
      add_s(10'h00C, 4'd3, 1'b0, 1'b1, 1'b0, 8'd0, 8'd2);
      add_s(10'h00C, 4'd3, 1'b0, 1'b1, 1'b0, 8'd0, 8'd2);
      add_s(10'h018, 4'd4, 1'b0, 1'b1, 1'b0, 8'd0, 8'd2);
      add_s(10'h060, 4'd4, 1'b0, 1'b0, 1'b1, 8'd1, 8'd2);
      add(1'b0, 1'b0, 10'h3FF, 4'd4, 1'b0, 1'b0, 1'b0, 8'd1, 8'd2);
      add_s(10'h000, 4'd4, 1'b0, 1'b0, 1'b0, 8'd1, 8'd2);
      add_s(10'h00F, 4'd4, 1'b0, 1'b0, 1'b0, 8'd1, 8'd2);
      add_s(10'h018, 4'd4, 1'b0, 1'b0, 1'b0, 8'd1, 8'd2);
      add_s(10'h00C, 4'd3, 1'b1, 1'b1, 1'b0, 8'd1, 8'd2);
      add_s(10'h006, 4'd2, 1'b1, 1'b1, 1'b0, 8'd1, 8'd2);
      add(1'b0, 1'b0, 10'h155, 4'd2, 1'b1, 1'b1, 1'b0, 8'd1, 8'd2);
      add_s(10'h3FF, 4'd2, 1'b1, 1'b0, 1'b1, 8'd2, 8'd2);
      add_s(10'h030, 4'd5, 1'b1, 1'b0, 1'b0, 8'd2, 8'd2);
      add_s(10'h030, 4'd5, 1'b1, 1'b0, 1'b0, 8'd2, 8'd2);
      add_s(10'h180, 4'd8, 1'b1, 1'b0, 1'b0, 8'd2, 8'd2);
      add_s(10'h000, 4'd8, 1'b1, 1'b0, 1'b0, 8'd2, 8'd2);
      add_s(10'h200, 4'd10, 1'b1, 1'b0, 1'b0, 8'd2, 8'd2);
      add_s(10'h300, 4'd9, 1'b1, 1'b1, 1'b0, 8'd2, 8'd2);
      add_s(10'h100, 4'd9, 1'b1, 1'b0, 1'b1, 8'd3, 8'd2);
      add_s(10'h001, 4'd0, 1'b1, 1'b0, 1'b0, 8'd3, 8'd2);
      add_s(10'h003, 4'd1, 1'b0, 1'b1, 1'b0, 8'd3, 8'd2);
      add(1'b1, 1'b1, 10'h006, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      add_s(10'h00C, 4'd3, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      add_s(10'h006, 4'd2, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
      add_s(10'h003, 4'd1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
      add_s(10'h001, 4'd0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
      add_s(10'h003, 4'd1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd1);

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].smp, vecs[i].led);
         check_all(i, vecs[i].pos, vecs[i].dir, vecs[i].lk, vecs[i].err,
                   vecs[i].ec, vecs[i].bc);
      end

      // Lock at pos 3, repeat frames, then idle with a noisy bus.
      step(1'b1, 1'b0, 10'h000);
      check("fsm_state_reset", 0, 32'(fsm_state), 32'd0);
      step(1'b0, 1'b1, 10'h006);
      step(1'b0, 1'b1, 10'h00C);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 10'h00C);
         check_all(100 + i, 4'd3, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
      end
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, 10'($urandom_range(0, 1023)));
         check("hold_pos", i, 32'(pos), 32'd3);
         check("hold_locked", i, 32'(locked), 32'd1);
         check("hold_err", i, 32'(err), 32'd0);
      end

      // 300 lock-then-break events: err_count must stop at 255.
      step(1'b1, 1'b0, 10'h000);
      for (int i = 0; i < 300; i++) begin
         step(1'b0, 1'b1, 10'h001);
         step(1'b0, 1'b1, 10'h003);
         step(1'b0, 1'b1, 10'h000);
         check("sat_err", i, 32'(err), 32'd1);
         check("sat_err_count", i, 32'(err_count), (i < 255) ? 32'(i + 1) : 32'd255);
      end
      step(1'b0, 1'b0, 10'h000);
      check("sat_err_clear", 0, 32'(err), 32'd0);

      // Reset in the middle of a sweep clears everything.
      step(1'b0, 1'b1, 10'h001);
      step(1'b0, 1'b1, 10'h003);
      step(1'b0, 1'b1, 10'h006);
      check("pre_reset_pos", 0, 32'(pos), 32'd2);
      step(1'b1, 1'b1, 10'h00C);
      check_all(200, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      check("fsm_state_midreset", 0, 32'(fsm_state), 32'd0);

      @(negedge clk);
      reset  = 1'b0;
      sample = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
